// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone classic-cycle initiator driven by a command/response handshake.
// Optional watchdog abort enabled by defining WB_INITIATOR_TIMEOUT_EN.
module wb_initiator #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic        r_cmd_ready;
    logic        r_cyc;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_dat;

`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
    logic          r_err;
    logic [CW-1:0] r_cnt;
    assign rsp_err_o = r_err;
`else
    assign rsp_err_o = 1'b0;
`endif

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;

    // Transaction FSM: accept command, run one bus cycle, hold response until consumed.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
            r_err       <= 1'b0;
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid_i && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_cyc       <= 1'b1;
                        r_we        <= cmd_we_i;
                        r_adr       <= cmd_adr_i;
                        r_dat       <= cmd_dat_i;
                        r_sel       <= cmd_sel_i;
`ifdef WB_INITIATOR_TIMEOUT_EN
                        r_cnt       <= '0;
`endif
                        r_state     <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (wbm_ack_i) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= r_we ? 32'd0 : wbm_dat_i;
`ifdef WB_INITIATOR_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                        r_state     <= S_RESP;
                    end
`ifdef WB_INITIATOR_TIMEOUT_EN
                    else begin
                        if (r_cnt != C_MAX)
                            r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST) begin
                            r_cyc       <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_dat   <= '0;
                            r_err       <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: directed stimulus with a response scoreboard for wb_initiator.
module tb_wb_initiator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack = 1'b0;
    logic [31:0] rdat = '0;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    wb_initiator #(.TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_ack_i(ack), .wbm_dat_i(rdat)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_we = w;
        cmd_adr = a;
        cmd_dat = d;
        cmd_sel = s;
        tick();
        cmd_valid = 1'b0;
        check("bus_cyc", {31'd0, cyc}, 32'd1);
        check("bus_we", {31'd0, we}, {31'd0, w});
        check("bus_adr", adr, a);
        check("bus_dat", wdat, d);
        check("bus_sel", {28'd0, sel}, {28'd0, s});
        check("busy_ready", {31'd0, cmd_ready}, 32'd0);
    endtask

    // Scoreboard monitor: every completed response handshake pops one expectation.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: got dat %h err %b expected no response", rsp_dat, rsp_err);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("rsp_dat", rsp_dat, e[31:0]);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < 3; i++) tick();
        check("rst_cyc", {31'd0, cyc}, 32'd0);
        check("rst_stb", {31'd0, stb}, 32'd0);
        check("rst_adr", adr, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_ready_held", {31'd0, cmd_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready_release", {31'd0, cmd_ready}, 32'd1);

        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("idle_ack_ignored", {31'd0, rsp_valid}, 32'd0);

        issue(1'b1, 32'h3000_0000, 32'hA5A5_1234, 4'hF);
        exp_q.push_back({1'b0, 32'h0});
        ack = 1'b1;
        rdat = 32'h1111_2222;
        tick();
        ack = 1'b0;
        check("wr_cyc_drop", {31'd0, cyc}, 32'd0);
        check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        tick();
        check("wr_ready_back", {31'd0, cmd_ready}, 32'd1);

        issue(1'b0, 32'h3000_0004, 32'h0, 4'hF);
        exp_q.push_back({1'b0, 32'hCAFE_F00D});
        for (int i = 0; i < 4; i++) begin
            check("rd_stb_held", {31'd0, stb}, 32'd1);
            if (i == 3) begin
                ack = 1'b1;
                rdat = 32'hCAFE_F00D;
            end
            tick();
        end
        ack = 1'b0;
        rdat = 32'hDEAD_BEEF;
        check("rd_stb_drop", {31'd0, stb}, 32'd0);
        tick();

        rsp_ready = 1'b0;
        issue(1'b0, 32'h3000_0008, 32'h5, 4'h3);
        ack = 1'b1;
        rdat = 32'h1234_5678;
        tick();
        ack = 1'b0;
        rdat = 32'h0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_dat", rsp_dat, 32'h1234_5678);
            check("bp_ready", {31'd0, cmd_ready}, 32'd0);
            check("bp_cyc", {31'd0, cyc}, 32'd0);
            tick();
        end
        cmd_valid = 1'b0;
        exp_q.push_back({1'b0, 32'h1234_5678});
        rsp_ready = 1'b1;
        tick();
        check("bp_done_ready", {31'd0, cmd_ready}, 32'd1);
        check("bp_done_valid", {31'd0, rsp_valid}, 32'd0);

`ifdef WB_INITIATOR_TIMEOUT_EN
        issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        rdat = 32'h7777_7777;
        exp_q.push_back({1'b1, 32'h0});
        for (int i = 0; i < 8; i++) begin
            check("to_stb_held", {31'd0, stb}, 32'd1);
            tick();
        end
        check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("to_err", {31'd0, rsp_err}, 32'd1);
        check("to_stb_drop", {31'd0, stb}, 32'd0);
        tick();

        issue(1'b0, 32'h3000_0014, 32'h0, 4'hF);
        exp_q.push_back({1'b0, 32'h0BAD_0008});
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                ack = 1'b1;
                rdat = 32'h0BAD_0008;
            end
            tick();
        end
        ack = 1'b0;
        check("ack8_err", {31'd0, rsp_err}, 32'd0);
        tick();
`else
        issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        for (int i = 0; i < 100; i++) tick();
        check("noto_stb", {31'd0, stb}, 32'd1);
        check("noto_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        exp_q.push_back({1'b0, 32'h4444_0001});
        ack = 1'b1;
        rdat = 32'h4444_0001;
        tick();
        ack = 1'b0;
        check("noto_err", {31'd0, rsp_err}, 32'd0);
        tick();
`endif

        issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        rst_n = 1'b0;
        tick();
        check("mid_rst_cyc", {31'd0, cyc}, 32'd0);
        check("mid_rst_stb", {31'd0, stb}, 32'd0);
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_rst_novalid", {31'd0, rsp_valid}, 32'd0);
        issue(1'b1, 32'h3000_0024, 32'h0102_0304, 4'h6);
        exp_q.push_back({1'b0, 32'h0});
        ack = 1'b1;
        rdat = 32'hFFFF_FFFF;
        tick();
        ack = 1'b0;
        check("post_rst_valid", {31'd0, rsp_valid}, 32'd1);
        tick();
        tick();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_initiator.md
# wb_initiator

Wishbone classic-cycle bus initiator that sits in the user project area and drives the user Wishbone slave port from a simple command/response handshake. It is the master-side counterpart of the management SoC's WB MI A path and lets on-chip logic (LA-driven sequencers, test engines) issue single 32-bit reads and writes to `user_proj_example`-style slaves. An optional watchdog terminates cycles that are never acknowledged.

## Interface
- `TIMEOUT`, 255: cycles with `wbm_stb_o` high and no `wbm_ack_i` before abort. Legal range is 1..65535.
- `wb_clk_i`  in  1  single clock for all logic.
- `wb_rst_n_i`  in  1  synchronous, active-low reset.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  command accepted when high together with `cmd_valid_i`.
- `cmd_we_i`  in  1  1 = write, 0 = read.
- `cmd_adr_i`  in  32  byte address.
- `cmd_dat_i`  in  32  write data.
- `cmd_sel_i`  in  4  byte enables.
- `rsp_valid_o`  out  1  response present.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_dat_o`  out  32  read data; 0 for writes and aborts.
- `rsp_err_o`  out  1  cycle aborted by timeout.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each  Wishbone control.
- `wbm_sel_o`  out  4  byte enables.
- `wbm_adr_o`  out  32  address.
- `wbm_dat_o`  out  32  write data.
- `wbm_ack_i`  in  1  slave acknowledge.
- `wbm_dat_i`  in  32  slave read data.

## Operation
- **FSM states:** IDLE, BUS, RESP.
- **IDLE:**
  - `cmd_ready_o`=1.
  - On `cmd_valid_i`&&`cmd_ready_o`, register we/adr/dat/sel onto the `wbm_*` outputs, clear the timeout counter, and go to BUS.
- **BUS:**
  - `wbm_cyc_o`=`wbm_stb_o`=1. Address, data, sel and we are held stable.
  - On `wbm_ack_i`:
    - Capture `wbm_dat_i` into `rsp_dat_o` for reads; load 0 for writes.
    - Set `rsp_err_o`=0.
    - Go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, set `rsp_err_o`=1, `rsp_dat_o`=0, and go to RESP.
- **RESP:**
  - `rsp_valid_o`=1. `cyc`/`stb` are low.
  - `rsp_dat_o`/`rsp_err_o` are held until `rsp_valid_o`&&`rsp_ready_i`, then go to IDLE.
- **Boundary rules:**
  - `wbm_ack_i` outside BUS is ignored.
  - `wbm_ack_i` in the same cycle the counter reaches `TIMEOUT`: ack wins, with `rsp_err_o`=0.
  - Commands are never accepted outside IDLE; there is no queuing.
  - Counter width is `$clog2(TIMEOUT+1)` and it saturates at `TIMEOUT`, never wrapping.
  - `wbm_dat_o` for reads is driven with the registered command data; slaves ignore it.
- **Reset (sync, active-low):**
  - FSM goes to IDLE and all outputs are 0, except `cmd_ready_o`, which is 1 from the first clock edge after reset is released. While reset is held, `cmd_ready_o`=0.
  - Reset mid-BUS drops `cyc`/`stb` at that edge; the pending transaction is lost and produces no response.

## Timing
- Command accepted at edge N → `wbm_cyc_o`/`wbm_stb_o` high from N through the ack edge.
- Ack sampled at edge M → `cyc`/`stb` low and `rsp_valid_o` high after M.
- Minimum turnaround with an immediate ack is 1 bus cycle plus 1 response cycle. Throughput is at most one transaction per 3 cycles (IDLE, BUS, RESP).
- Timeout: `rsp_valid_o` rises after edge N+`TIMEOUT` when no ack arrives.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `WB_INITIATOR_TIMEOUT_EN`:
  - **Defined:** the watchdog counter and the abort path exist as described above.
  - **Undefined:** no counter is instantiated, BUS waits indefinitely for ack, `rsp_err_o` is tied to 0, and `TIMEOUT` is ignored.

## Test plan
- **Reset:** hold `wb_rst_n_i`=0 for 3 cycles → all `wbm_*` are 0, `rsp_valid_o`=0, and `cmd_ready_o`=1 one edge after release.
- **Write:** adr 0x3000_0000, dat 0xA5A5_1234, sel 0xF, slave acks 1 cycle after stb → bus shows exact adr/dat/sel with we=1, then response with `rsp_dat_o`=0 and `rsp_err_o`=0.
- **Read:** adr 0x3000_0004, slave returns 0xCAFE_F00D with ack after 3 wait cycles → `rsp_dat_o`=0xCAFE_F00D; `cyc`/`stb` held high for 4 cycles total.
- **Backpressure:** hold `rsp_ready_i`=0 for 5 cycles → `rsp_valid_o` and data stay stable and `cmd_ready_o` stays 0 until the response handshake completes.
- **Timeout** (macro defined, `TIMEOUT`=8):
  - No ack → `rsp_err_o`=1 after 8 BUS cycles.
  - Ack on cycle 8 → `rsp_err_o`=0.
  - With the macro undefined, 100 cycles without ack → still in BUS.
- **Reset mid-BUS:** assert reset while `stb` is high → `cyc`/`stb` drop at that edge, no `rsp_valid_o` appears, and the next command completes normally.
